// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo sequencer: owns the logo position and direction, walks the logo
// ROM in raster order across the logo window and registers the pixel colour.
module logo_motion_ctrl #(
    parameter int         LOGO_W    = 200,
    parameter int         LOGO_H    = 100,
    parameter int         H_ACTIVE  = 640,
    parameter int         V_ACTIVE  = 480,
    parameter int         STEP_X    = 1,
    parameter int         STEP_Y    = 1,
    parameter int         FRAME_DIV = 1,
    parameter logic [5:0] BG_COLOR  = 6'h3F
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        p_tick,
    input  logic        vsync,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pause,
    input  logic [7:0]  rom_data,
    output logic [15:0] rom_addr,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        in_window,
    output logic [5:0]  rgb
);
    // state      | meaning
    // WAIT_FRAME | idle, counting vsync rising edges toward the next update
    // UPD_X      | apply horizontal step, bounce at 0 / XMAX
    // UPD_Y      | apply vertical step, bounce at 0 / YMAX
    localparam logic [10:0] XMAX      = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] YMAX      = 11'(V_ACTIVE - LOGO_H);
    localparam logic [10:0] LW        = 11'(LOGO_W);
    localparam logic [10:0] LH        = 11'(LOGO_H);
    localparam logic [10:0] SX        = 11'(STEP_X);
    localparam logic [10:0] SY        = 11'(STEP_Y);
    localparam logic [7:0]  DIV_LAST  = 8'(FRAME_DIV - 1);
    localparam logic [15:0] ADDR_LAST = 16'(LOGO_W * LOGO_H - 1);

    typedef enum logic [1:0] {WAIT_FRAME = 2'd0, UPD_X = 2'd1, UPD_Y = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_frame_cnt, w_frame_cnt_nxt;
    logic [9:0]  r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic        r_dir_x_neg, r_dir_y_neg, w_dir_x_neg_nxt, w_dir_y_neg_nxt;
    logic        r_vsync_d;
    logic [15:0] r_rom_addr;
    logic [5:0]  r_rgb;
    logic        w_frame_start;
    logic [10:0] w_pos_x11, w_pos_y11, w_px11, w_py11, w_x_inc, w_y_inc;
    logic [9:0]  w_x_dec, w_y_dec;
    logic        w_unused_rom;

    // 11-bit arithmetic keeps pos+LOGO_W and pos+STEP from wrapping
    assign w_pos_x11 = {1'b0, r_pos_x};
    assign w_pos_y11 = {1'b0, r_pos_y};
    assign w_px11    = {1'b0, pixel_x};
    assign w_py11    = {1'b0, pixel_y};
    assign w_x_inc   = w_pos_x11 + SX;
    assign w_y_inc   = w_pos_y11 + SY;
    assign w_x_dec   = r_pos_x - SX[9:0];
    assign w_y_dec   = r_pos_y - SY[9:0];

    assign in_window = (w_px11 >= w_pos_x11) && (w_px11 < w_pos_x11 + LW) &&
                       (w_py11 >= w_pos_y11) && (w_py11 < w_pos_y11 + LH);
    assign w_frame_start = vsync & ~r_vsync_d;
    assign w_unused_rom  = ^rom_data[7:6];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= WAIT_FRAME;
            r_frame_cnt <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
            r_vsync_d   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_pos_x     <= w_pos_x_nxt;
            r_pos_y     <= w_pos_y_nxt;
            r_dir_x_neg <= w_dir_x_neg_nxt;
            r_dir_y_neg <= w_dir_y_neg_nxt;
            r_vsync_d   <= vsync;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_pos_x_nxt     = r_pos_x;
        w_pos_y_nxt     = r_pos_y;
        w_dir_x_neg_nxt = r_dir_x_neg;
        w_dir_y_neg_nxt = r_dir_y_neg;
        case (r_state)
            WAIT_FRAME: begin
                if (w_frame_start) begin
                    if (r_frame_cnt == DIV_LAST) begin
                        w_frame_cnt_nxt = '0;
                        if (!pause) w_state_nxt = UPD_X;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            UPD_X: begin
                if (!r_dir_x_neg) begin
                    if (w_x_inc >= XMAX) begin
                        w_pos_x_nxt     = XMAX[9:0];
                        w_dir_x_neg_nxt = 1'b1;
                    end else begin
                        w_pos_x_nxt = w_x_inc[9:0];
                    end
                end else if (w_pos_x11 <= SX) begin
                    w_pos_x_nxt     = '0;
                    w_dir_x_neg_nxt = 1'b0;
                end else begin
                    w_pos_x_nxt = w_x_dec;
                end
                w_state_nxt = UPD_Y;
            end
            UPD_Y: begin
                if (!r_dir_y_neg) begin
                    if (w_y_inc >= YMAX) begin
                        w_pos_y_nxt     = YMAX[9:0];
                        w_dir_y_neg_nxt = 1'b1;
                    end else begin
                        w_pos_y_nxt = w_y_inc[9:0];
                    end
                end else if (w_pos_y11 <= SY) begin
                    w_pos_y_nxt     = '0;
                    w_dir_y_neg_nxt = 1'b0;
                end else begin
                    w_pos_y_nxt = w_y_dec;
                end
                w_state_nxt = WAIT_FRAME;
            end
            default: w_state_nxt = WAIT_FRAME;
        endcase
    end

    // ROM read is combinational, so the address and the colour share one tick
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rom_addr <= '0;
            r_rgb      <= '0;
        end else begin
            if (vsync) begin
                r_rom_addr <= '0;
            end else if (p_tick && video_on && in_window) begin
                r_rom_addr <= (r_rom_addr == ADDR_LAST) ? '0 : r_rom_addr + 16'd1;
            end
            if (p_tick) begin
                if (video_on && in_window) r_rgb <= rom_data[5:0];
                else if (video_on)         r_rgb <= BG_COLOR;
                else                       r_rgb <= '0;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign rgb      = r_rgb;
endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Scoreboard bench for logo_motion_ctrl: two instances (default geometry and a
// fast-stepping, divided, corner-hitting one) checked every cycle against a model.
module tb_logo_motion_ctrl;
    localparam int NDUT = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        reset_i, vsync, pause;
    logic        p_tick_s[NDUT], video_on_s[NDUT];
    logic [9:0]  pixel_x_s[NDUT], pixel_y_s[NDUT];
    logic [7:0]  rom_data_s[NDUT];
    logic [15:0] rom_addr_w[NDUT];
    logic [9:0]  pos_x_w[NDUT], pos_y_w[NDUT];
    logic        in_window_w[NDUT];
    logic [5:0]  rgb_w[NDUT];

    typedef struct { int lw, lh, xmax, ymax, sx, sy, div, bg; } cfg_t;
    typedef struct { int px, py, dx, dy, fcnt, addr, rgb; bit vs_d, x_due, y_due; } mst_t;
    typedef struct { int dut, win, px, py, addr, rgb; } exp_t;

    mst_t m[NDUT];
    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [15:0] t;
        t = (a * 16'd37) ^ (a >> 3);
        return t[7:0] ^ 8'h5A;
    endfunction

    assign rom_data_s[0] = rom_fn(rom_addr_w[0]);
    assign rom_data_s[1] = rom_fn(rom_addr_w[1]);

    logo_motion_ctrl u_dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .p_tick(p_tick_s[0]), .vsync(vsync),
        .video_on(video_on_s[0]), .pixel_x(pixel_x_s[0]), .pixel_y(pixel_y_s[0]),
        .pause(pause), .rom_data(rom_data_s[0]), .rom_addr(rom_addr_w[0]),
        .pos_x(pos_x_w[0]), .pos_y(pos_y_w[0]), .in_window(in_window_w[0]), .rgb(rgb_w[0]));

    logo_motion_ctrl #(.LOGO_W(8), .LOGO_H(4), .H_ACTIVE(228), .V_ACTIVE(384),
                       .STEP_X(11), .STEP_Y(19), .FRAME_DIV(4), .BG_COLOR(6'h15)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .p_tick(p_tick_s[1]), .vsync(vsync),
        .video_on(video_on_s[1]), .pixel_x(pixel_x_s[1]), .pixel_y(pixel_y_s[1]),
        .pause(pause), .rom_data(rom_data_s[1]), .rom_addr(rom_addr_w[1]),
        .pos_x(pos_x_w[1]), .pos_y(pos_y_w[1]), .in_window(in_window_w[1]), .rgb(rgb_w[1]));

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        if (i == 0) begin
            c.lw = 200; c.lh = 100; c.xmax = 440; c.ymax = 380;
            c.sx = 1;   c.sy = 1;   c.div = 1;    c.bg = 63;
        end else begin
            c.lw = 8;   c.lh = 4;   c.xmax = 220; c.ymax = 380;
            c.sx = 11;  c.sy = 19;  c.div = 4;    c.bg = 21;
        end
        return c;
    endfunction

    function automatic mst_t m_reset();
        mst_t s;
        s.px = 0; s.py = 0; s.dx = 1; s.dy = 1; s.fcnt = 0; s.addr = 0; s.rgb = 0;
        s.vs_d = 1'b0; s.x_due = 1'b0; s.y_due = 1'b0;
        return s;
    endfunction

    function automatic bit m_win(input cfg_t c, input mst_t s, input int x, input int y);
        return (x >= s.px) && (x < s.px + c.lw) && (y >= s.py) && (y < s.py + c.lh);
    endfunction

    // one axis of motion: step toward the current edge, clamp and reverse on reaching it
    function automatic void bounce(input int step, input int lim, input int p_in, input int d_in,
                                   output int p, output int d);
        if (d_in > 0) begin
            if (p_in + step >= lim) begin p = lim; d = -1; end
            else begin p = p_in + step; d = 1; end
        end else begin
            if (p_in <= step) begin p = 0; d = 1; end
            else begin p = p_in - step; d = -1; end
        end
    endfunction

    function automatic mst_t m_edge(input cfg_t c, input mst_t s, input bit vs, input bit pz,
                                    input bit pt, input bit von, input int x, input int y);
        mst_t n;
        bit   win;
        int   np, nd;
        n   = s;
        win = m_win(c, s, x, y);
        if (vs) n.addr = 0;
        else if (pt && von && win) n.addr = (s.addr == c.lw * c.lh - 1) ? 0 : s.addr + 1;
        if (pt) n.rgb = (von && win) ? int'(rom_fn(16'(s.addr)) & 8'h3F) : (von ? c.bg : 0);
        n.x_due = 1'b0;
        n.y_due = 1'b0;
        if (s.x_due) begin
            bounce(c.sx, c.xmax, s.px, s.dx, np, nd);
            n.px = np; n.dx = nd; n.y_due = 1'b1;
        end
        if (s.y_due) begin
            bounce(c.sy, c.ymax, s.py, s.dy, np, nd);
            n.py = np; n.dy = nd;
        end
        if (vs && !s.vs_d) begin
            if (s.fcnt == c.div - 1) begin
                n.fcnt = 0;
                if (!pz) n.x_due = 1'b1;
            end else begin
                n.fcnt = s.fcnt + 1;
            end
        end
        n.vs_d = vs;
        return n;
    endfunction

    task automatic tick();
        exp_t e;
        if (!reset_i) for (int i = 0; i < NDUT; i++) m[i] = m_reset();
        for (int i = 0; i < NDUT; i++) begin
            e.dut  = i;
            e.win  = int'(m_win(get_cfg(i), m[i], int'(pixel_x_s[i]), int'(pixel_y_s[i])));
            e.px   = m[i].px;
            e.py   = m[i].py;
            e.addr = m[i].addr;
            e.rgb  = m[i].rgb;
            q.push_back(e);
        end
        @(posedge clk_i);
        if (reset_i)
            for (int i = 0; i < NDUT; i++)
                m[i] = m_edge(get_cfg(i), m[i], vsync, pause, p_tick_s[i], video_on_s[i],
                              int'(pixel_x_s[i]), int'(pixel_y_s[i]));
        #1;
    endtask

    task automatic rand_px(input int i);
        cfg_t c;
        int   x, y;
        int   xs[4], ys[4];
        c = get_cfg(i);
        case ($urandom_range(0, 3))
            0: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
            3: begin
                xs = '{m[i].px - 1, m[i].px, m[i].px + c.lw - 1, m[i].px + c.lw};
                ys = '{m[i].py - 1, m[i].py, m[i].py + c.lh - 1, m[i].py + c.lh};
                x = xs[$urandom_range(0, 3)];
                y = ys[$urandom_range(0, 3)];
            end
            default: begin
                x = m[i].px + $urandom_range(0, c.lw - 1);
                y = m[i].py + $urandom_range(0, c.lh - 1);
            end
        endcase
        pixel_x_s[i]  = 10'(x);
        pixel_y_s[i]  = 10'(y);
        p_tick_s[i]   = ($urandom_range(0, 3) != 0);
        video_on_s[i] = ($urandom_range(0, 4) != 0);
    endtask

    task automatic frame(input int n_act, input bit pz);
        pause = pz;
        vsync = 1'b0;
        repeat (n_act) begin rand_px(0); rand_px(1); tick(); end
        vsync = 1'b1;
        repeat (3) begin rand_px(0); rand_px(1); tick(); end
        vsync = 1'b0;
    endtask

    // full raster of dut0's window in one frame, ending past the address wrap
    task automatic raster_frame();
        int ox, oy;
        vsync = 1'b0;
        pause = 1'b0;
        ox = m[0].px;
        oy = m[0].py;
        for (int yy = 0; yy < 102; yy++) begin
            for (int xx = 0; xx < 200; xx++) begin
                pixel_x_s[0]  = 10'(ox + xx);
                pixel_y_s[0]  = 10'(oy + (yy % 100));
                p_tick_s[0]   = 1'b1;
                video_on_s[0] = 1'b1;
                rand_px(1);
                tick();
                if (yy == 100 && xx == 2) break;
            end
            if (yy == 100) break;
        end
    endtask

    task automatic cmp(input string nm, input int d, input int got, input int want);
        if (got != want) begin
            n_mis++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, d, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                cmp("in_window", e.dut, int'(in_window_w[e.dut]), e.win);
                cmp("pos_x",     e.dut, int'(pos_x_w[e.dut]),     e.px);
                cmp("pos_y",     e.dut, int'(pos_y_w[e.dut]),     e.py);
                cmp("rom_addr",  e.dut, int'(rom_addr_w[e.dut]),  e.addr);
                cmp("rgb",       e.dut, int'(rgb_w[e.dut]),       e.rgb);
            end
        end
    end

    initial begin : stimulus
        reset_i = 1'b0;
        vsync   = 1'b0;
        pause   = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            m[i]          = m_reset();
            p_tick_s[i]   = 1'b0;
            video_on_s[i] = 1'b0;
            pixel_x_s[i]  = '0;
            pixel_y_s[i]  = '0;
        end
        @(posedge clk_i);
        #1;
        repeat (5) tick();
        reset_i = 1'b1;

        repeat (20) frame(8, 1'b0);
        repeat (8)  frame(8, 1'b1);
        repeat (10) frame(8, 1'b0);
        for (int f = 0; f < 900; f++) frame($urandom_range(2, 10), $urandom_range(0, 9) == 0);
        raster_frame();
        repeat (5) frame(8, 1'b0);

        vsync = 1'b0;
        repeat (40) begin rand_px(0); rand_px(1); tick(); end
        reset_i = 1'b0;
        repeat (3) begin rand_px(0); rand_px(1); tick(); end
        reset_i = 1'b1;
        repeat (30) frame(8, 1'b0);

        repeat (2) @(negedge clk_i);
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
